// File: rtl/led_seq_pkg.sv
// Shared types and pattern helpers for the LED mode sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_CHASE = 2'b10,
    MODE_COUNT = 2'b11
  } mode_e;

  localparam logic [1:0] BLINK_ENTRY = 2'b11;
  localparam logic [1:0] CHASE_ENTRY = 2'b01;
  localparam logic [1:0] COUNT_ENTRY = 2'b00;

  // Pattern shown on the edge a mode is entered.
  function automatic logic [1:0] entry_pattern(input mode_e m);
    logic [1:0] p;
    p = 2'b00;
    case (m)
      MODE_BLINK: p = BLINK_ENTRY;
      MODE_CHASE: p = CHASE_ENTRY;
      MODE_COUNT: p = COUNT_ENTRY;
      default:    p = 2'b00;
    endcase
    return p;
  endfunction

  // Pattern that follows 'led' on a prescaler step in mode 'm'.
  function automatic logic [1:0] step_pattern(input mode_e m, input logic [1:0] led);
    logic [1:0] p;
    p = 2'b00;
    case (m)
      MODE_BLINK: p = ~led;
      MODE_CHASE: p = (led == 2'b01) ? 2'b10 : 2'b01;
      MODE_COUNT: p = led + 2'b01;
      default:    p = 2'b00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_mode_sequencer_debounce.sv
// Whole-vector switch debouncer: a new value is accepted only after it has
// been sampled on DEBOUNCE_CYCLES consecutive edges.
module sw_debounce #(
  parameter int W               = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DCNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  cand;
  logic [CW-1:0] dcnt;

  // Track the candidate value and how long it has been stable; any change restarts the run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q  <= '0;
      cand <= '0;
      dcnt <= '0;
    end else if (i_d == o_q) begin
      dcnt <= '0;
    end else if (i_d != cand) begin
      cand <= i_d;
      dcnt <= CW'(1);
    end else if (dcnt == DCNT_LAST) begin
      o_q  <= i_d;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: debounced 2-bit switch selects off/blink/chase/count,
// and a prescaler steps the selected pattern every TICK_CYCLES clocks.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_CYCLES     = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_sw,
  output logic [1:0] o_led,
  output logic [1:0] o_mode,
  output logic       o_tick
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_CYCLES - 1);

  logic [1:0]    sw_db;
  mode_e         state, next_state;
  logic [1:0]    led_next;
  logic [PW-1:0] pcnt, pcnt_next;
  logic          tick_next;

  sw_debounce #(
    .W               (2),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_sw),
    .o_q     (sw_db)
  );

  assign o_mode = state;

  // Mode change wins over a prescaler wrap; OFF holds everything at zero.
  always_comb begin
    next_state = state;
    led_next   = o_led;
    pcnt_next  = pcnt;
    tick_next  = 1'b0;
    if (sw_db != state) begin
      next_state = mode_e'(sw_db);
      led_next   = entry_pattern(mode_e'(sw_db));
      pcnt_next  = '0;
    end else if (state == MODE_OFF) begin
      led_next  = 2'b00;
      pcnt_next = '0;
    end else if (pcnt == PCNT_LAST) begin
      pcnt_next = '0;
      tick_next = 1'b1;
      led_next  = step_pattern(state, o_led);
    end else begin
      pcnt_next = pcnt + PW'(1);
    end
  end

  // Register mode, pattern, prescaler and tick pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= MODE_OFF;
      o_led  <= 2'b00;
      pcnt   <= '0;
      o_tick <= 1'b0;
    end else begin
      state  <= next_state;
      o_led  <= led_next;
      pcnt   <= pcnt_next;
      o_tick <= tick_next;
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer with a run-length/elapsed-time model.
module tb_led_mode_sequencer;

  localparam int DEB  = 4;
  localparam int TICK = 3;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [1:0] i_sw = 2'b00;
  logic [1:0] o_led;
  logic [1:0] o_mode;
  logic       o_tick;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0] m_db = 2'b00;
  logic [1:0] m_last = 2'b00;
  int         m_run = 0;
  logic [1:0] m_mode = 2'b00;
  logic [1:0] m_led = 2'b00;
  logic       m_tick = 1'b0;
  int         m_elapsed = 0;

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .TICK_CYCLES     (TICK)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sw    (i_sw),
    .o_led   (o_led),
    .o_mode  (o_mode),
    .o_tick  (o_tick)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 i_clk = ~i_clk;

  // Pattern after 'step' prescaler steps in mode m, from the mode's rules.
  function automatic logic [1:0] expected_pattern(input logic [1:0] m, input int step);
    logic [1:0] p;
    p = 2'b00;
    case (m)
      2'b01:   p = (step % 2 == 0) ? 2'b11 : 2'b00;
      2'b10:   p = (step % 2 == 0) ? 2'b01 : 2'b10;
      2'b11:   p = 2'(step % 4);
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  // Behavioural model: outputs follow the debounced value of the previous edge;
  // the debounced value takes a switch value once it has been seen on DEB consecutive edges.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_db = 2'b00; m_last = 2'b00; m_run = 0;
      m_mode = 2'b00; m_led = 2'b00; m_tick = 1'b0; m_elapsed = 0;
    end else begin
      if (m_db != m_mode) begin
        m_mode = m_db; m_elapsed = 0; m_tick = 1'b0;
        m_led = expected_pattern(m_mode, 0);
      end else if (m_mode == 2'b00) begin
        m_tick = 1'b0; m_led = 2'b00; m_elapsed = 0;
      end else begin
        m_elapsed++;
        m_tick = (m_elapsed % TICK == 0);
        m_led = expected_pattern(m_mode, m_elapsed / TICK);
      end
      if (m_run > 0 && i_sw == m_last) m_run++;
      else m_run = 1;
      m_last = i_sw;
      if (m_run >= DEB && i_sw != m_db) m_db = i_sw;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge i_clk) begin
    checks++;
    if ({o_led, o_mode, o_tick} !== {m_led, m_mode, m_tick}) begin
      errors++;
      $display("[TB] FAIL model_compare t=%0t: got led=%b mode=%b tick=%b, want led=%b mode=%b tick=%b",
               $time, o_led, o_mode, o_tick, m_led, m_mode, m_tick);
    end
  end

  task automatic checkOutput(input string name, input logic [1:0] e_led,
                             input logic [1:0] e_mode, input logic e_tick);
    checks++;
    if (o_led !== e_led || o_mode !== e_mode || o_tick !== e_tick) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got led=%b mode=%b tick=%b, want led=%b mode=%b tick=%b",
               name, $time, o_led, o_mode, o_tick, e_led, e_mode, e_tick);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sw);
    i_sw = sw;
  endtask

  task automatic stepEdge();
    @(posedge i_clk);
    #1;
  endtask

  // Advance until o_tick is seen, bounded by a cycle budget.
  task automatic waitTick(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      stepEdge();
      if (o_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no tick in %0d cycles, want a tick", name, budget);
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    stepEdge();
    checkOutput("after_reset", 2'b00, 2'b00, 1'b0);

    // Test 1: async reset out of COUNT mode
    applyStimulus(2'b11);
    repeat (5) stepEdge();
    checkOutput("count_entry", 2'b00, 2'b11, 1'b0);
    repeat (4) stepEdge();
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 checkOutput("async_reset", 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stepEdge();
      checkOutput("post_reset_idle", 2'b00, 2'b00, 1'b0);
    end

    // Test 2: debounce latency and first blink steps
    applyStimulus(2'b01);
    repeat (4) stepEdge();
    checkOutput("blink_edge4", 2'b00, 2'b00, 1'b0);
    stepEdge();
    checkOutput("blink_edge5", 2'b11, 2'b01, 1'b0);
    repeat (3) stepEdge();
    checkOutput("blink_edge8", 2'b00, 2'b01, 1'b1);
    stepEdge();
    checkOutput("blink_edge9", 2'b00, 2'b01, 1'b0);
    repeat (2) stepEdge();
    checkOutput("blink_edge11", 2'b11, 2'b01, 1'b1);

    // Test 6: back to OFF, then silence
    applyStimulus(2'b00);
    repeat (4) stepEdge();
    checkOutput("off_edge4", o_led, 2'b01, o_tick);
    stepEdge();
    checkOutput("off_edge5", 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 100; i++) begin
      stepEdge();
      checkOutput("off_quiet", 2'b00, 2'b00, 1'b0);
    end

    // Test 3: glitch restarts the debounce count
    for (int i = 0; i < 11; i++) begin
      applyStimulus((i < 3 || (i >= 4 && i < 7)) ? 2'b01 : 2'b00);
      stepEdge();
      checkOutput("glitch_reject", 2'b00, 2'b00, 1'b0);
    end

    // Test 4: chase then count with wrap
    applyStimulus(2'b10);
    repeat (5) stepEdge();
    checkOutput("chase_entry", 2'b01, 2'b10, 1'b0);
    waitTick("chase_t1", 10); checkOutput("chase_t1", 2'b10, 2'b10, 1'b1);
    waitTick("chase_t2", 10); checkOutput("chase_t2", 2'b01, 2'b10, 1'b1);
    waitTick("chase_t3", 10); checkOutput("chase_t3", 2'b10, 2'b10, 1'b1);
    applyStimulus(2'b11);
    repeat (5) stepEdge();
    checkOutput("count_entry2", 2'b00, 2'b11, 1'b0);
    waitTick("count_t1", 10); checkOutput("count_t1", 2'b01, 2'b11, 1'b1);
    waitTick("count_t2", 10); checkOutput("count_t2", 2'b10, 2'b11, 1'b1);
    waitTick("count_t3", 10); checkOutput("count_t3", 2'b11, 2'b11, 1'b1);
    waitTick("count_wrap", 10); checkOutput("count_wrap", 2'b00, 2'b11, 1'b1);

    // Test 5: mode change lands on the prescaler wrap edge
    waitTick("align_tick", 10);
    stepEdge();
    applyStimulus(2'b01);
    repeat (5) stepEdge();
    checkOutput("align_entry", 2'b11, 2'b01, 1'b0);
    stepEdge(); checkOutput("align_p1", 2'b11, 2'b01, 1'b0);
    stepEdge(); checkOutput("align_p2", 2'b11, 2'b01, 1'b0);
    stepEdge(); checkOutput("align_step", 2'b00, 2'b01, 1'b1);

    // Random phase: random switch hold lengths and occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      applyStimulus(2'($urandom_range(0, 3)));
      repeat ($urandom_range(1, 10)) stepEdge();
      if ($urandom_range(0, 14) == 0) begin
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge i_clk);
        #2 i_rst_n = 1'b1;
      end
    end
    repeat (3) stepEdge();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
